rop_top: RTL and testbench

Render-output (ROP) back end for a 4x-MSAA tile framebuffer. It accepts one shaded fragment at a time through a valid/ack handshake and performs a per-sample strict-less depth test against an on-chip 16-bit depth buffer. For every covered sample that passes, it writes the fragment colour and depth. It sits after the rasteriser/shader stage and owns the WIDTH×HEIGHT colour and depth storage, which a debug read port exposes.

---
 rtl/rop_top_if.sv | 20 ++
 rtl/rop_top.sv | 148 ++++++++++++++
 tb/tb_rop_top.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rop_top_if.sv
// rtl/rop_top_if.sv - fragment handshake bundle between shader stage and ROP
interface rop_top_if;
    logic        frag_valid;
    logic [31:0] frag_x;
    logic [31:0] frag_y;
    logic [31:0] frag_color;
    logic [15:0] frag_depth;
    logic [3:0]  frag_sample_mask;
    logic        write_ack;

    modport master (
        output frag_valid, frag_x, frag_y, frag_color, frag_depth, frag_sample_mask,
        input  write_ack
    );

    modport slave (
        input  frag_valid, frag_x, frag_y, frag_color, frag_depth, frag_sample_mask,
        output write_ack
    );
endinterface

// File: rtl/rop_top.sv
// rtl/rop_top.sv - 4x-MSAA ROP back end: strict-less depth test, colour/depth write, debug readback
module rop_top #(
    parameter  int WIDTH  = 32,
    parameter  int HEIGHT = 32,
    localparam int NPIX   = WIDTH * HEIGHT,
    localparam int AW     = $clog2(NPIX)
) (
    input  logic            clk,
    input  logic            rst,
    rop_top_if.slave        frag,
    output logic            init_done,
    input  logic [AW-1:0]   rd_pix,
    input  logic [1:0]      rd_sample,
    output logic [31:0]     rd_color,
    output logic [15:0]     rd_depth
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_WRITE, S_ACK} state_e;

    state_e        state_q;
    logic [31:0]   x_q, y_q, color_q;
    logic [15:0]   depth_q;
    logic [3:0]    mask_q;
    logic [AW-1:0] clear_q, pix_q;
    logic          inrange_q;
    logic          write_ack_q, init_done_q;
    logic [31:0]   rd_color_q;
    logic [15:0]   rd_depth_q;
    logic [15:0]   stored_q [4];

    logic [31:0]   color_mem [4][NPIX];
    logic [15:0]   depth_mem [4][NPIX];

    logic [AW-1:0] pix_d;
    logic          inrange_d;
    logic [3:0]    pass;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_color;
    logic [15:0]   mem_depth;

    // Range test uses the full 32-bit coordinates; pix is only meaningful when in range.
    always_comb begin
        inrange_d = (x_q < 32'(WIDTH)) && (y_q < 32'(HEIGHT));
        pix_d     = AW'(y_q) * AW'(WIDTH) + AW'(x_q);
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            pass[s] = mask_q[s] && inrange_q && (depth_q < stored_q[s]);
        end
    end

    always_comb begin
        mem_we    = '0;
        mem_addr  = pix_q;
        mem_color = color_q;
        mem_depth = depth_q;
        if (state_q == S_INIT) begin
            mem_we    = 4'hF;
            mem_addr  = clear_q;
            mem_color = '0;
            mem_depth = 16'hFFFF;
        end else if (state_q == S_WRITE) begin
            mem_we = pass;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (mem_we[s]) begin
                color_mem[s][mem_addr] <= mem_color;
                depth_mem[s][mem_addr] <= mem_depth;
            end
            if (state_q == S_READ) begin
                stored_q[s] <= depth_mem[s][pix_d];
            end
        end
    end

    // Debug port reads old data when a pipeline write hits the same word on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_color_q <= '0;
            rd_depth_q <= '0;
        end else begin
            rd_color_q <= color_mem[rd_sample][rd_pix];
            rd_depth_q <= depth_mem[rd_sample][rd_pix];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            clear_q     <= '0;
            init_done_q <= 1'b0;
            write_ack_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            depth_q     <= '0;
            mask_q      <= '0;
            pix_q       <= '0;
            inrange_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (clear_q == AW'(NPIX - 1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        clear_q <= clear_q + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (frag.frag_valid) begin
                        x_q     <= frag.frag_x;
                        y_q     <= frag.frag_y;
                        color_q <= frag.frag_color;
                        depth_q <= frag.frag_depth;
                        mask_q  <= frag.frag_sample_mask;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    pix_q     <= pix_d;
                    inrange_q <= inrange_d;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    write_ack_q <= 1'b1;
                    state_q     <= S_ACK;
                end
                S_ACK: begin
                    write_ack_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign frag.write_ack = write_ack_q;
    assign init_done      = init_done_q;
    assign rd_color       = rd_color_q;
    assign rd_depth       = rd_depth_q;

endmodule

// File: tb/tb_rop_top.sv
// tb/tb_rop_top.sv - directed and random checks of rop_top against a per-sample reference model
module tb_rop_top;
    localparam int NPIX = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic [9:0]  rd_pix = '0;
    logic [1:0]  rd_sample = '0;
    logic [31:0] rd_color;
    logic [15:0] rd_depth;

    rop_top_if f ();

    rop_top dut (
        .clk       (clk),
        .rst       (rst),
        .frag      (f),
        .init_done (init_done),
        .rd_pix    (rd_pix),
        .rd_sample (rd_sample),
        .rd_color  (rd_color),
        .rd_depth  (rd_depth)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_col [4][NPIX];
    logic [15:0] m_dep [4][NPIX];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < NPIX; p++) begin
                m_col[s][p] = '0;
                m_dep[s][p] = 16'hFFFF;
            end
        end
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!init_done && cnt < 2000);
        chk("init_cycles", cnt, NPIX);
    endtask

    task automatic rd(input int p, input int s, output logic [31:0] c, output logic [15:0] d);
        rd_pix    = p[9:0];
        rd_sample = s[1:0];
        @(negedge clk);
        c = rd_color;
        d = rd_depth;
    endtask

    task automatic check_all(input string tag);
        int errs;
        logic [31:0] c;
        logic [15:0] d;
        errs = 0;
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < NPIX; p++) begin
                rd(p, s, c, d);
                if (c !== m_col[s][p] || d !== m_dep[s][p]) errs++;
            end
        end
        chk(tag, errs, 0);
    endtask

    // Called at a negedge; returns at a negedge so back-to-back calls hit acceptance at A+4.
    task automatic send_frag(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                             input logic [15:0] z, input logic [3:0] m);
        int lat;
        int p;
        f.frag_valid       = 1'b1;
        f.frag_x           = x;
        f.frag_y           = y;
        f.frag_color       = c;
        f.frag_depth       = z;
        f.frag_sample_mask = m;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!f.write_ack && lat < 20);
        f.frag_valid = 1'b0;
        chk("ack_latency", lat, 3);
        @(negedge clk);
        chk("ack_pulse", {31'b0, f.write_ack}, 0);
        if (x < 32 && y < 32) begin
            p = int'(y) * 32 + int'(x);
            for (int s = 0; s < 4; s++) begin
                if (m[s] && z < m_dep[s][p]) begin
                    m_col[s][p] = c;
                    m_dep[s][p] = z;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] c;
        logic [15:0] d;

        f.frag_valid       = 1'b0;
        f.frag_x           = '0;
        f.frag_y           = '0;
        f.frag_color       = '0;
        f.frag_depth       = '0;
        f.frag_sample_mask = '0;

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, f.write_ack}, 0);
        chk("rst_init_done", {31'b0, init_done}, 0);
        chk("rst_rd_color", rd_color, 0);
        chk("rst_rd_depth", {16'b0, rd_depth}, 0);

        rst = 1'b0;
        wait_init();
        clear_model();
        check_all("cleared");

        send_frag(10, 10, 32'hFF0000FF, 16'd100, 4'b1111);
        send_frag(10, 10, 32'h00FF00FF, 16'd50, 4'b1111);
        for (int s = 0; s < 4; s++) begin
            rd(330, s, c, d);
            chk("p330_color", c, 32'h00FF00FF);
            chk("p330_depth", {16'b0, d}, 32'd50);
        end
        send_frag(10, 10, 32'h12345678, 16'd50, 4'b1111);
        rd(330, 2, c, d);
        chk("equal_z_color", c, 32'h00FF00FF);
        chk("equal_z_depth", {16'b0, d}, 32'd50);

        send_frag(3, 4, 32'hAABBCCDD, 16'd200, 4'b0101);
        rd(131, 0, c, d);
        chk("m5_s0_color", c, 32'hAABBCCDD);
        rd(131, 1, c, d);
        chk("m5_s1_depth", {16'b0, d}, 32'h0000FFFF);
        chk("m5_s1_color", c, 32'h0);
        rd(131, 2, c, d);
        chk("m5_s2_depth", {16'b0, d}, 32'd200);
        rd(131, 3, c, d);
        chk("m5_s3_color", c, 32'h0);
        send_frag(3, 4, 32'h11223344, 16'd100, 4'b1111);
        for (int s = 0; s < 4; s++) begin
            rd(131, s, c, d);
            chk("p131_over_color", c, 32'h11223344);
            chk("p131_over_depth", {16'b0, d}, 32'd100);
        end

        send_frag(32, 0, 32'hDEADBEEF, 16'd1, 4'b1111);
        send_frag(0, 40, 32'hDEADBEEF, 16'd1, 4'b1111);
        send_frag(32'h8000_0001, 0, 32'hDEADBEEF, 16'd1, 4'b1111);
        send_frag(5, 5, 32'hDEADBEEF, 16'd1, 4'b0000);
        send_frag(6, 6, 32'hDEADBEEF, 16'hFFFF, 4'b1111);
        check_all("no_pass_unchanged");

        // Reset while the fragment is in READ: it must vanish and the clear must restart.
        f.frag_valid       = 1'b1;
        f.frag_x           = 10;
        f.frag_y           = 10;
        f.frag_color       = 32'hCAFEF00D;
        f.frag_depth       = 16'd10;
        f.frag_sample_mask = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        f.frag_valid = 1'b0;
        #1;
        chk("midrst_init_done", {31'b0, init_done}, 0);
        chk("midrst_ack", {31'b0, f.write_ack}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ack_hold", {31'b0, f.write_ack}, 0);
        rst = 1'b0;
        wait_init();
        clear_model();
        rd(330, 0, c, d);
        chk("midrst_p330_depth", {16'b0, d}, 32'h0000FFFF);
        chk("midrst_p330_color", c, 32'h0);

        for (int i = 0; i < 1000; i++) begin
            send_frag($urandom_range(0, 31), $urandom_range(0, 3), $urandom,
                      16'($urandom_range(0, 65535)), 4'($urandom_range(1, 15)));
        end
        check_all("random_model");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
